// File: rtl/rsa_probe_pkg.sv
// Shared definitions for the RSA timing probe.
// - state_t : probe FSM encoding (IDLE, LAUNCH, WAIT, REPORT)
// - P_W/M_W : operand widths of the RSA core (primes, plaintext)
// - *_DEF   : default counter width, timeout and run-counter width
package rsa_probe_pkg;
  localparam int P_W         = 8;
  localparam int M_W         = 16;
  localparam int CNT_W_DEF   = 20;
  localparam int TIMEOUT_DEF = 500000;
  localparam int RUN_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } state_t;
endpackage

// File: rtl/rsa_timing_probe_if.sv
// Command / result bus of the RSA timing probe.
// - cmd_valid/cmd_ready/cmd_p/cmd_q/cmd_m : one operand set per accept
// - res_valid     : one-cycle result strobe
// - res_cycles/res_match/res_timeout : held until the next strobe
// master = command issuer, slave = probe.
interface rsa_timing_probe_if #(
  parameter int CNT_W = 20
);
  import rsa_probe_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [P_W-1:0]   cmd_p;
  logic [P_W-1:0]   cmd_q;
  logic [M_W-1:0]   cmd_m;
  logic             res_valid;
  logic [CNT_W-1:0] res_cycles;
  logic             res_match;
  logic             res_timeout;

  modport master (
    output cmd_valid, cmd_p, cmd_q, cmd_m,
    input  cmd_ready, res_valid, res_cycles, res_match, res_timeout
  );

  modport slave (
    input  cmd_valid, cmd_p, cmd_q, cmd_m,
    output cmd_ready, res_valid, res_cycles, res_match, res_timeout
  );
endinterface

// File: rtl/rsa_latency_stats.sv
// Running min/max/count of measured RSA latencies.
// - sample_valid/sample : one latency per strobe
// - clear_stats         : returns all stats to reset values; beats a sample
// - stat_min/stat_max/stat_runs : min starts at all ones, runs saturates
module rsa_latency_stats #(
  parameter int CNT_W = 20,
  parameter int RUN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic [CNT_W-1:0] sample,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] stat_min,
  output logic [CNT_W-1:0] stat_max,
  output logic [RUN_W-1:0] stat_runs
);
  always_ff @(posedge clk) begin
    if (!rst_n || clear_stats) begin
      stat_min  <= '1;
      stat_max  <= '0;
      stat_runs <= '0;
    end else if (sample_valid) begin
      if (sample < stat_min) stat_min <= sample;
      if (sample > stat_max) stat_max <= sample;
      if (stat_runs != '1)   stat_runs <= stat_runs + 1'b1;
    end
  end
endmodule

// File: rtl/rsa_timing_probe.sv
// Timing probe / initiator for the RSA core start-finish handshake.
// - bus (slave)   : command accept in IDLE, result strobe in REPORT
// - rsa_start/p/q/m : one-cycle launch pulse; operands are zero otherwise
// - rsa_finish/rsa_m_decrypted : completion level and result from the core
// - clear_stats, stat_min/stat_max/stat_runs : latency statistics
// Latency k = number of WAIT cycles up to and including the finish cycle.
module rsa_timing_probe
  import rsa_probe_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int RUN_W   = RUN_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  rsa_timing_probe_if.slave  bus,
  output logic               rsa_start,
  output logic [P_W-1:0]     rsa_p,
  output logic [P_W-1:0]     rsa_q,
  output logic [M_W-1:0]     rsa_m,
  input  logic [M_W-1:0]     rsa_m_decrypted,
  input  logic               rsa_finish,
  input  logic               clear_stats,
  output logic [CNT_W-1:0]   stat_min,
  output logic [CNT_W-1:0]   stat_max,
  output logic [RUN_W-1:0]   stat_runs
);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [M_W-1:0]   lat_m;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.cmd_ready   <= 1'b1;
      rsa_start       <= 1'b0;
      rsa_p           <= '0;
      rsa_q           <= '0;
      rsa_m           <= '0;
      bus.res_valid   <= 1'b0;
      bus.res_cycles  <= '0;
      bus.res_match   <= 1'b0;
      bus.res_timeout <= 1'b0;
      cnt             <= '0;
      lat_m           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            lat_m         <= bus.cmd_m;
            rsa_start     <= 1'b1;
            rsa_p         <= bus.cmd_p;
            rsa_q         <= bus.cmd_q;
            rsa_m         <= bus.cmd_m;
            bus.cmd_ready <= 1'b0;
            cnt           <= '0;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          // finish may still be high from the previous run; not looked at here
          rsa_start <= 1'b0;
          rsa_p     <= '0;
          rsa_q     <= '0;
          rsa_m     <= '0;
          cnt       <= cnt + 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (rsa_finish) begin
            bus.res_cycles  <= cnt;
            bus.res_match   <= (rsa_m_decrypted == lat_m);
            bus.res_timeout <= 1'b0;
            bus.res_valid   <= 1'b1;
            state           <= REPORT;
          end else if (cnt == TO_VAL) begin
            bus.res_cycles  <= TO_VAL;
            bus.res_match   <= 1'b0;
            bus.res_timeout <= 1'b1;
            bus.res_valid   <= 1'b1;
            state           <= REPORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPORT: begin
          bus.res_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // stats fold in the result during the REPORT cycle it is presented
  logic sample_valid;
  assign sample_valid = (state == REPORT) && !bus.res_timeout;

  rsa_latency_stats #(
    .CNT_W (CNT_W),
    .RUN_W (RUN_W)
  ) u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (bus.res_cycles),
    .clear_stats  (clear_stats),
    .stat_min     (stat_min),
    .stat_max     (stat_max),
    .stat_runs    (stat_runs)
  );
endmodule

// File: tb/tb_rsa_timing_probe.sv
module tb_rsa_timing_probe;
  import rsa_probe_pkg::*;

  localparam int CW = 20;
  localparam int TO = 100;
  localparam int RW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            rsa_start, rsa_finish, clear_stats;
  logic [P_W-1:0]  rsa_p, rsa_q;
  logic [M_W-1:0]  rsa_m, rsa_m_decrypted;
  logic [CW-1:0]   stat_min, stat_max;
  logic [RW-1:0]   stat_runs;

  rsa_timing_probe_if #(.CNT_W(CW)) bus ();

  rsa_timing_probe #(.CNT_W(CW), .TIMEOUT(TO), .RUN_W(RW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus.slave),
    .rsa_start       (rsa_start),
    .rsa_p           (rsa_p),
    .rsa_q           (rsa_q),
    .rsa_m           (rsa_m),
    .rsa_m_decrypted (rsa_m_decrypted),
    .rsa_finish      (rsa_finish),
    .clear_stats     (clear_stats),
    .stat_min        (stat_min),
    .stat_max        (stat_max),
    .stat_runs       (stat_runs)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // RSA core model: finish level rises in WAIT cycle 'lat' and stays high
  // until the first WAIT cycle of the next run (so it is stale in LAUNCH).
  int            lat = 1;
  logic [M_W-1:0] dec_val = '0;
  int            w = 0;
  bit            arm = 0;
  initial begin rsa_finish = 1'b0; rsa_m_decrypted = '0; end
  always @(negedge clk) begin
    if (!rst_n) begin
      arm = 0; w = 0; rsa_finish = 1'b0;
    end else if (rsa_start) begin
      arm = 1; w = 0;
    end else if (arm) begin
      w++;
      if (w >= lat) begin
        rsa_finish = 1'b1;
        rsa_m_decrypted = dec_val;
      end else begin
        rsa_finish = 1'b0;
      end
    end
  end

  // bus monitor, reset per run
  int start_cnt, bus_bad, acc_cnt, rdy_bad;
  logic [P_W-1:0] ep, eq;
  logic [M_W-1:0] em;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsa_start) begin
        start_cnt++;
        if (rsa_p !== ep || rsa_q !== eq || rsa_m !== em) bus_bad++;
        if (bus.cmd_ready) rdy_bad++;
      end else if (rsa_p != 0 || rsa_q != 0 || rsa_m != 0) begin
        bus_bad++;
      end
      if (bus.cmd_valid && bus.cmd_ready) acc_cnt++;
      if (bus.res_valid && bus.cmd_ready) rdy_bad++;
    end
  end

  // reference statistics
  logic [CW-1:0] m_min = '1;
  logic [CW-1:0] m_max = '0;
  logic [RW-1:0] m_runs = '0;

  task automatic stats_reset();
    m_min = '1; m_max = '0; m_runs = '0;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_min"},  32'(stat_min),  32'(m_min));
    chk({tag, "_max"},  32'(stat_max),  32'(m_max));
    chk({tag, "_runs"}, 32'(stat_runs), 32'(m_runs));
  endtask

  task automatic run(input logic [P_W-1:0] p, input logic [P_W-1:0] q,
                     input logic [M_W-1:0] m, input int l,
                     input logic [M_W-1:0] dv, input bit clr, input bit hold);
    bit got;
    bit exp_to;
    int exp_cyc;
    bit exp_match;
    @(posedge clk); #2;
    lat = l; dec_val = dv; ep = p; eq = q; em = m;
    start_cnt = 0; bus_bad = 0; acc_cnt = 0; rdy_bad = 0;
    bus.cmd_valid = 1'b1; bus.cmd_p = p; bus.cmd_q = q; bus.cmd_m = m;
    if (!hold) begin @(posedge clk); #2; bus.cmd_valid = 1'b0; end
    got = 0;
    for (int n = 0; n < TO + 20; n++) begin
      @(negedge clk);
      if (bus.res_valid) begin got = 1; break; end
    end
    bus.cmd_valid = 1'b0;
    chk("res_seen", 32'(got), 1);
    if (got) begin
      if (clr) clear_stats = 1'b1;
      exp_to    = (l > TO);
      exp_cyc   = exp_to ? TO : l;
      exp_match = !exp_to && (dv == m);
      chk("res_cycles",  32'(bus.res_cycles),  32'(exp_cyc));
      chk("res_match",   32'(bus.res_match),   32'(exp_match));
      chk("res_timeout", 32'(bus.res_timeout), 32'(exp_to));
      if (clr) stats_reset();
      else if (!exp_to) begin
        if (CW'(exp_cyc) < m_min) m_min = CW'(exp_cyc);
        if (CW'(exp_cyc) > m_max) m_max = CW'(exp_cyc);
        if (m_runs != '1) m_runs = m_runs + 1'b1;
      end
      @(negedge clk);
      clear_stats = 1'b0;
      chk("res_pulse",  32'(bus.res_valid),  0);
      chk("res_hold",   32'(bus.res_cycles), 32'(exp_cyc));
      chk("ready_idle", 32'(bus.cmd_ready),  1);
      chk("start_once", 32'(start_cnt), 1);
      chk("rsa_bus",    32'(bus_bad),   0);
      chk("accepts",    32'(acc_cnt),   1);
      chk("ready_busy", 32'(rdy_bad),   0);
      chk_stats("stats");
    end
  endtask

  initial begin
    clear_stats = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_p = '0; bus.cmd_q = '0; bus.cmd_m = '0;
    start_cnt = 0; bus_bad = 0; acc_cnt = 0; rdy_bad = 0;
    ep = '0; eq = '0; em = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",   32'(bus.cmd_ready), 1);
    chk("rst_start",   32'(rsa_start), 0);
    chk("rst_ops",     32'({rsa_p, rsa_q} | rsa_m), 0);
    chk("rst_rvalid",  32'(bus.res_valid), 0);
    chk("rst_rcycles", 32'(bus.res_cycles), 0);
    chk("rst_rflags",  32'({bus.res_match, bus.res_timeout}), 0);
    chk_stats("rst");
    @(posedge clk); #2; rst_n = 1'b1;

    run(8'd53, 8'd59, 16'd89, 37, 16'd89, 0, 0);   // basic
    run(8'd53, 8'd59, 16'd89, 45, 16'd88, 0, 0);   // mismatch, still counted
    run(8'd61, 8'd67, 16'd1234, 1000, 16'd1234, 0, 0); // timeout
    run(8'd3, 8'd5, 16'd7, 60, 16'd7, 1, 0);       // clear in REPORT
    chk_stats("clr");
    run(8'd11, 8'd13, 16'd100, 50, 16'd100, 0, 0);
    run(8'd17, 8'd19, 16'd200, 20, 16'd200, 0, 0);
    run(8'd23, 8'd29, 16'd300, 80, 16'd300, 0, 1); // cmd_valid held
    chk("s3_min",  32'(stat_min),  20);
    chk("s3_max",  32'(stat_max),  80);
    chk("s3_runs", 32'(stat_runs), 3);
    run(8'd31, 8'd37, 16'd400, TO, 16'd400, 0, 1);     // finish beats timeout
    run(8'd41, 8'd43, 16'd500, TO + 1, 16'd500, 0, 0); // first timeout value
    run(8'd47, 8'd53, 16'd600, 1, 16'd600, 0, 0);      // shortest latency

    for (int i = 0; i < 10; i++) begin
      logic [M_W-1:0] mm, dd;
      mm = M_W'($urandom);
      dd = ($urandom_range(0, 3) == 0) ? (mm ^ M_W'($urandom_range(1, 65535))) : mm;
      run(P_W'($urandom), P_W'($urandom), mm, $urandom_range(1, TO + 10), dd,
          ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1);
    end

    // reset in WAIT cycle 10
    begin
      bit hit;
      @(posedge clk); #2;
      lat = 1000; ep = 8'd71; eq = 8'd73; em = 16'd999; dec_val = 16'd999;
      bus.cmd_valid = 1'b1; bus.cmd_p = 8'd71; bus.cmd_q = 8'd73; bus.cmd_m = 16'd999;
      @(posedge clk); #2; bus.cmd_valid = 1'b0;
      hit = 0;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (arm && w == 10) begin hit = 1; break; end
      end
      chk("wait10_seen", 32'(hit), 1);
      rst_n = 1'b0;
      @(negedge clk);
      stats_reset();
      chk("mrst_ready",  32'(bus.cmd_ready), 1);
      chk("mrst_rvalid", 32'(bus.res_valid), 0);
      chk("mrst_start",  32'(rsa_start), 0);
      chk("mrst_rcyc",   32'(bus.res_cycles), 0);
      chk_stats("mrst");
      @(posedge clk); #2; rst_n = 1'b1;
    end
    run(8'd53, 8'd59, 16'd89, 37, 16'd89, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
